mem_access_unit_p: RTL and testbench

Parametrised memory-access pipeline stage between the execute unit and write-back, successor to the fixed two-stage, word-only access unit. It adds:
- configurable data width (32/64) and memory read latency;
- byte-lane alignment of sub-word loads and byte strobes for stores;
- misalignment detection that suppresses the access;
- a full per-stage bypass/not-ready vector for the execute unit's hazard logic.

---
 rtl/mem_access_unit_p.sv | 213 +++++++++++++++++++++
 tb/tb_mem_access_unit_p.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_p.sv
// mem_access_unit_p: memory-access pipeline stage between execute and write-back.
//   Issues aligned memory requests combinationally from the execute inputs.
//   Carries each instruction through RD_LAT stage registers, then formats
//   load data or passes the ALU result to write-back.
// Ports:
//   clk, rstn          clock and synchronous active-low reset
//   i_exec_*           instruction presented by execute (valid/type/len/addr/data/rd/res)
//   o_mem_*            aligned address, read/write strobes, byte strobes, lane-shifted store data
//   i_mem_data_r       aligned read word, valid RD_LAT cycles after o_mem_read_en
//   o_wb_*             write-back valid/rd/result from the oldest stage
//   o_byp_*            per-stage rd/result/forwardable flags (stage 0 youngest)
//   o_reg_not_ready    registers with a load still in flight
//   o_misaligned*      one-cycle misalignment pulse and held offending address
module mem_access_unit_p #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_exec_valid,
  input  logic                     i_exec_load,
  input  logic                     i_exec_store,
  input  logic [1:0]               i_exec_len,
  input  logic                     i_exec_is_signed,
  input  logic [XLEN-1:0]          i_exec_addr,
  input  logic [XLEN-1:0]          i_exec_data_w,
  input  logic [4:0]               i_exec_rd,
  input  logic [XLEN-1:0]          i_exec_res,
  output logic [XLEN-1:0]          o_mem_addr,
  output logic                     o_mem_read_en,
  output logic                     o_mem_write_en,
  output logic [XLEN/8-1:0]        o_mem_wstrb,
  output logic [XLEN-1:0]          o_mem_data_w,
  input  logic [XLEN-1:0]          i_mem_data_r,
  output logic                     o_wb_valid,
  output logic [4:0]               o_wb_rd,
  output logic [XLEN-1:0]          o_wb_res,
  output logic [5*RD_LAT-1:0]      o_byp_rd,
  output logic [XLEN*RD_LAT-1:0]   o_byp_data,
  output logic [RD_LAT-1:0]        o_byp_ok,
  output logic [31:0]              o_reg_not_ready,
  output logic                     o_misaligned,
  output logic [XLEN-1:0]          o_misaligned_addr
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = (XLEN == 64) ? 3 : 2;
  localparam int unsigned OLD  = RD_LAT - 1;

  // Request decode
  logic            req_load;
  logic            req_store;
  logic            misal;
  logic [OFFW-1:0] req_off;
  logic [OFFW-1:0] align_mask;
  logic [NB-1:0]   base_strb;

  always_comb begin
    req_store  = i_exec_valid & i_exec_store;
    // Load and store together behave as a store.
    req_load   = i_exec_valid & i_exec_load & ~i_exec_store;
    req_off    = i_exec_addr[OFFW-1:0];
    align_mask = '0;
    for (int unsigned i = 0; i < OFFW; i++) begin
      if (i < 32'(i_exec_len)) align_mask[i] = 1'b1;
    end
    misal = (req_load | req_store) &
            (((i_exec_len == 2'd3) && (XLEN == 32)) | (|(req_off & align_mask)));
    base_strb = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i < (32'd1 << i_exec_len)) base_strb[i] = 1'b1;
    end
  end

  always_comb begin
    o_mem_addr     = '0;
    o_mem_read_en  = 1'b0;
    o_mem_write_en = 1'b0;
    o_mem_wstrb    = '0;
    o_mem_data_w   = '0;
    if (rstn) begin
      o_mem_addr     = {i_exec_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
      o_mem_read_en  = req_load & ~misal;
      o_mem_write_en = req_store & ~misal;
      if (req_store & ~misal) begin
        o_mem_wstrb  = base_strb << req_off;
        o_mem_data_w = i_exec_data_w << {req_off, 3'b000};
      end
    end
  end

  // Stage registers, stage 0 youngest
  logic            v_q   [RD_LAT];
  logic            v_d   [RD_LAT];
  logic            ld_q  [RD_LAT];
  logic            ld_d  [RD_LAT];
  logic [4:0]      rd_q  [RD_LAT];
  logic [4:0]      rd_d  [RD_LAT];
  logic [XLEN-1:0] res_q [RD_LAT];
  logic [XLEN-1:0] res_d [RD_LAT];
  logic [1:0]      len_q [RD_LAT];
  logic [1:0]      len_d [RD_LAT];
  logic            sg_q  [RD_LAT];
  logic            sg_d  [RD_LAT];
  logic [OFFW-1:0] off_q [RD_LAT];
  logic [OFFW-1:0] off_d [RD_LAT];
  logic            misal_q;
  logic            misal_d;
  logic [XLEN-1:0] maddr_q;
  logic [XLEN-1:0] maddr_d;

  always_comb begin
    // Misaligned requests enter as bubbles; stores carry rd=0 so they never forward.
    v_d[0]   = i_exec_valid & ~misal;
    ld_d[0]  = req_load & ~misal;
    rd_d[0]  = req_store ? 5'd0 : i_exec_rd;
    res_d[0] = i_exec_res;
    len_d[0] = i_exec_len;
    sg_d[0]  = i_exec_is_signed;
    off_d[0] = req_off;
    for (int unsigned k = 1; k < RD_LAT; k++) begin
      v_d[k]   = v_q[k-1];
      ld_d[k]  = ld_q[k-1];
      rd_d[k]  = rd_q[k-1];
      res_d[k] = res_q[k-1];
      len_d[k] = len_q[k-1];
      sg_d[k]  = sg_q[k-1];
      off_d[k] = off_q[k-1];
    end
    misal_d = misal;
    maddr_d = misal ? i_exec_addr : maddr_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < RD_LAT; k++) begin
        v_q[k]   <= 1'b0;
        ld_q[k]  <= 1'b0;
        rd_q[k]  <= '0;
        res_q[k] <= '0;
        len_q[k] <= '0;
        sg_q[k]  <= 1'b0;
        off_q[k] <= '0;
      end
      misal_q <= 1'b0;
      maddr_q <= '0;
    end else begin
      for (int unsigned k = 0; k < RD_LAT; k++) begin
        v_q[k]   <= v_d[k];
        ld_q[k]  <= ld_d[k];
        rd_q[k]  <= rd_d[k];
        res_q[k] <= res_d[k];
        len_q[k] <= len_d[k];
        sg_q[k]  <= sg_d[k];
        off_q[k] <= off_d[k];
      end
      misal_q <= misal_d;
      maddr_q <= maddr_d;
    end
  end

  // Write-back from the oldest stage
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_res;
  int unsigned     wbits;
  logic            sbit;

  always_comb begin
    ld_shift = i_mem_data_r >> {off_q[OLD], 3'b000};
    wbits    = 32'd8 << len_q[OLD];
    if (wbits > XLEN) wbits = XLEN;
    sbit = 1'b0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      if (i == wbits - 1) sbit = sg_q[OLD] & ld_shift[i];
    end
    for (int unsigned i = 0; i < XLEN; i++) begin
      ld_res[i] = (i < wbits) ? ld_shift[i] : sbit;
    end
    // A load to x0 still accessed memory but produces no write-back.
    o_wb_valid = rstn & v_q[OLD] & ~(ld_q[OLD] & (rd_q[OLD] == 5'd0));
    o_wb_rd    = '0;
    o_wb_res   = '0;
    if (o_wb_valid) begin
      o_wb_rd  = rd_q[OLD];
      o_wb_res = ld_q[OLD] ? ld_res : res_q[OLD];
    end
  end

  // Bypass / hazard view of every stage
  always_comb begin
    o_byp_rd        = '0;
    o_byp_data      = '0;
    o_byp_ok        = '0;
    o_reg_not_ready = '0;
    for (int unsigned k = 0; k < RD_LAT; k++) begin
      if (rstn & v_q[k]) begin
        o_byp_rd[5*k +: 5] = rd_q[k];
        if (ld_q[k]) begin
          if (rd_q[k] != 5'd0) o_reg_not_ready[rd_q[k]] = 1'b1;
        end else begin
          o_byp_data[XLEN*k +: XLEN] = res_q[k];
          o_byp_ok[k]                = (rd_q[k] != 5'd0);
        end
      end
    end
  end

  always_comb begin
    o_misaligned      = rstn & misal_q;
    o_misaligned_addr = rstn ? maddr_q : '0;
  end

endmodule

// File: tb/tb_mem_access_unit_p.sv
module tb_mem_access_unit_p;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DUT A: XLEN=32, RD_LAT=2
  logic        a_v, a_ld, a_st, a_sg;
  logic [1:0]  a_len;
  logic [31:0] a_addr, a_dw, a_res, a_mem_r;
  logic [4:0]  a_rd;
  logic [31:0] a_mem_addr, a_mem_dw, a_wb_res, a_nr, a_mis_addr;
  logic        a_rd_en, a_wr_en, a_wb_valid, a_mis;
  logic [3:0]  a_wstrb;
  logic [4:0]  a_wb_rd;
  logic [9:0]  a_byp_rd;
  logic [63:0] a_byp_data;
  logic [1:0]  a_byp_ok;

  mem_access_unit_p #(.XLEN(32), .RD_LAT(2)) u_a (
    .clk(clk), .rstn(rstn),
    .i_exec_valid(a_v), .i_exec_load(a_ld), .i_exec_store(a_st), .i_exec_len(a_len),
    .i_exec_is_signed(a_sg), .i_exec_addr(a_addr), .i_exec_data_w(a_dw),
    .i_exec_rd(a_rd), .i_exec_res(a_res),
    .o_mem_addr(a_mem_addr), .o_mem_read_en(a_rd_en), .o_mem_write_en(a_wr_en),
    .o_mem_wstrb(a_wstrb), .o_mem_data_w(a_mem_dw), .i_mem_data_r(a_mem_r),
    .o_wb_valid(a_wb_valid), .o_wb_rd(a_wb_rd), .o_wb_res(a_wb_res),
    .o_byp_rd(a_byp_rd), .o_byp_data(a_byp_data), .o_byp_ok(a_byp_ok),
    .o_reg_not_ready(a_nr), .o_misaligned(a_mis), .o_misaligned_addr(a_mis_addr)
  );

  // DUT B: XLEN=64, RD_LAT=3
  logic        b_v, b_ld, b_st, b_sg;
  logic [1:0]  b_len;
  logic [63:0] b_addr, b_dw, b_res, b_mem_r;
  logic [4:0]  b_rd;
  logic [63:0] b_mem_addr, b_mem_dw, b_wb_res, b_mis_addr;
  logic [31:0] b_nr;
  logic        b_rd_en, b_wr_en, b_wb_valid, b_mis;
  logic [7:0]  b_wstrb;
  logic [4:0]  b_wb_rd;
  logic [14:0] b_byp_rd;
  logic [191:0] b_byp_data;
  logic [2:0]  b_byp_ok;

  mem_access_unit_p #(.XLEN(64), .RD_LAT(3)) u_b (
    .clk(clk), .rstn(rstn),
    .i_exec_valid(b_v), .i_exec_load(b_ld), .i_exec_store(b_st), .i_exec_len(b_len),
    .i_exec_is_signed(b_sg), .i_exec_addr(b_addr), .i_exec_data_w(b_dw),
    .i_exec_rd(b_rd), .i_exec_res(b_res),
    .o_mem_addr(b_mem_addr), .o_mem_read_en(b_rd_en), .o_mem_write_en(b_wr_en),
    .o_mem_wstrb(b_wstrb), .o_mem_data_w(b_mem_dw), .i_mem_data_r(b_mem_r),
    .o_wb_valid(b_wb_valid), .o_wb_rd(b_wb_rd), .o_wb_res(b_wb_res),
    .o_byp_rd(b_byp_rd), .o_byp_data(b_byp_data), .o_byp_ok(b_byp_ok),
    .o_reg_not_ready(b_nr), .o_misaligned(b_mis), .o_misaligned_addr(b_mis_addr)
  );

  task automatic a_drv(input logic v, input logic ld, input logic st, input logic [1:0] len,
                       input logic sg, input logic [31:0] addr, input logic [31:0] dw,
                       input logic [4:0] rd, input logic [31:0] res);
    a_v = v; a_ld = ld; a_st = st; a_len = len; a_sg = sg;
    a_addr = addr; a_dw = dw; a_rd = rd; a_res = res;
  endtask

  task automatic b_drv(input logic v, input logic ld, input logic st, input logic [1:0] len,
                       input logic sg, input logic [63:0] addr, input logic [63:0] dw,
                       input logic [4:0] rd, input logic [63:0] res);
    b_v = v; b_ld = ld; b_st = st; b_len = len; b_sg = sg;
    b_addr = addr; b_dw = dw; b_rd = rd; b_res = res;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    b_drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    a_mem_r = '0;
    b_mem_r = '0;

    // Reset cycle with a store presented: strobes must stay gated
    cyc();
    a_drv(1, 0, 1, 2'd0, 0, 32'h103, 32'hAB, 5'd7, 32'h55);
    #1;
    chk("rst_wr_en", 64'(a_wr_en), 64'd0);
    chk("rst_wb_valid", 64'(a_wb_valid), 64'd0);
    chk("rst_not_ready", 64'(a_nr), 64'd0);
    chk("rst_misaligned", 64'(a_mis), 64'd0);
    chk("rst_byp_ok", 64'(a_byp_ok), 64'd0);

    // C1: sb 0xAB @0x103 on A; ld x10 @0x8 on B
    cyc();
    rstn = 1'b1;
    a_drv(1, 0, 1, 2'd0, 0, 32'h103, 32'hAB, 5'd7, 32'h55);
    b_drv(1, 1, 0, 2'd3, 0, 64'h8, 64'h0, 5'd10, 64'h0);
    #1;
    chk("sb_wr_en", 64'(a_wr_en), 64'd1);
    chk("sb_rd_en", 64'(a_rd_en), 64'd0);
    chk("sb_wstrb", 64'(a_wstrb), 64'h8);
    chk("sb_data_w", 64'(a_mem_dw), 64'hAB000000);
    chk("sb_mem_addr", 64'(a_mem_addr), 64'h100);
    chk("ld64_rd_en", 64'(b_rd_en), 64'd1);
    chk("ld64_mem_addr", b_mem_addr, 64'h8);

    // C2: idle
    cyc();
    a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    b_drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("sb_wr_en_drop", 64'(a_wr_en), 64'd0);
    chk("sb_wstrb_drop", 64'(a_wstrb), 64'd0);
    chk("st_byp_ok", 64'(a_byp_ok), 64'd0);
    chk("st_byp_rd", 64'(a_byp_rd), 64'd0);

    // C3: store reaches write-back with rd forced to 0
    cyc();
    #1;
    chk("st_wb_valid", 64'(a_wb_valid), 64'd1);
    chk("st_wb_rd", 64'(a_wb_rd), 64'd0);
    chk("st_wb_res", 64'(a_wb_res), 64'h55);

    // C4: lb x3 @0x103 signed on A; B ld write-back
    cyc();
    a_drv(1, 1, 0, 2'd0, 1, 32'h103, 0, 5'd3, 0);
    b_mem_r = 64'h1122334455667788;
    #1;
    chk("lb_rd_en", 64'(a_rd_en), 64'd1);
    chk("lb_mem_addr", 64'(a_mem_addr), 64'h100);
    chk("ld64_wb_valid", 64'(b_wb_valid), 64'd1);
    chk("ld64_wb_rd", 64'(b_wb_rd), 64'd10);
    chk("ld64_wb_res", b_wb_res, 64'h1122334455667788);

    // C5: lbu x4 @0x103 on A; sw 0xCAFEBABE @0x14 on B
    cyc();
    a_drv(1, 1, 0, 2'd0, 0, 32'h103, 0, 5'd4, 0);
    b_drv(1, 0, 1, 2'd2, 0, 64'h14, 64'hCAFEBABE, 5'd1, 0);
    b_mem_r = '0;
    #1;
    chk("lb_not_ready", 64'(a_nr), 64'h8);
    chk("sw64_wr_en", 64'(b_wr_en), 64'd1);
    chk("sw64_wstrb", 64'(b_wstrb), 64'hF0);
    chk("sw64_data_w", b_mem_dw, 64'hCAFEBABE00000000);

    // C6: lh x9 @0x102 signed on A; lb write-back; lw x12 signed @0x14 on B
    cyc();
    a_drv(1, 1, 0, 2'd1, 1, 32'h102, 0, 5'd9, 0);
    a_mem_r = 32'h80000000;
    b_drv(1, 1, 0, 2'd2, 1, 64'h14, 0, 5'd12, 0);
    #1;
    chk("two_loads_not_ready", 64'(a_nr), 64'h18);
    chk("lb_wb_valid", 64'(a_wb_valid), 64'd1);
    chk("lb_wb_rd", 64'(a_wb_rd), 64'd3);
    chk("lb_wb_res", 64'(a_wb_res), 64'hFFFFFF80);

    // C7: lbu write-back
    cyc();
    a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    b_drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("lbu_wb_rd", 64'(a_wb_rd), 64'd4);
    chk("lbu_wb_res", 64'(a_wb_res), 64'h80);
    chk("lh_lbu_not_ready", 64'(a_nr), 64'h210);

    // C8: lh write-back
    cyc();
    #1;
    chk("lh_wb_rd", 64'(a_wb_rd), 64'd9);
    chk("lh_wb_res", 64'(a_wb_res), 64'hFFFF8000);

    // C9: B lw signed write-back from upper lane
    cyc();
    b_mem_r = 64'h8000000100000000;
    #1;
    chk("lw64_wb_rd", 64'(b_wb_rd), 64'd12);
    chk("lw64_wb_res", b_wb_res, 64'hFFFFFFFF80000001);

    // C10: misaligned lh @0x101
    cyc();
    a_drv(1, 1, 0, 2'd1, 0, 32'h101, 0, 5'd2, 0);
    b_mem_r = '0;
    #1;
    chk("mis_rd_en", 64'(a_rd_en), 64'd0);
    chk("mis_wr_en", 64'(a_wr_en), 64'd0);

    // C11
    cyc();
    a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("mis_pulse", 64'(a_mis), 64'd1);
    chk("mis_addr", 64'(a_mis_addr), 64'h101);
    chk("mis_not_ready", 64'(a_nr), 64'd0);

    // C12
    cyc();
    #1;
    chk("mis_pulse_end", 64'(a_mis), 64'd0);
    chk("mis_wb_valid", 64'(a_wb_valid), 64'd0);
    chk("mis_addr_hold", 64'(a_mis_addr), 64'h101);

    // C13: len=3 is illegal at XLEN=32
    cyc();
    a_drv(1, 1, 0, 2'd3, 0, 32'h8, 0, 5'd3, 0);
    #1;
    chk("len3_rd_en", 64'(a_rd_en), 64'd0);

    // C14
    cyc();
    a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("len3_mis", 64'(a_mis), 64'd1);
    chk("len3_mis_addr", 64'(a_mis_addr), 64'h8);

    // C15: lw x5 @0x200
    cyc();
    a_drv(1, 1, 0, 2'd2, 0, 32'h200, 0, 5'd5, 0);
    #1;
    chk("lw_rd_en", 64'(a_rd_en), 64'd1);

    // C16: add x6 = 0x1234
    cyc();
    a_drv(1, 0, 0, 2'd0, 0, 0, 0, 5'd6, 32'h1234);
    #1;
    chk("haz_not_ready_t1", 64'(a_nr), 64'h20);

    // C17: lw write-back; add in stage 0
    cyc();
    a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    a_mem_r = 32'hDEADBEEF;
    #1;
    chk("haz_not_ready_t2", 64'(a_nr), 64'h20);
    chk("haz_byp_ok", 64'(a_byp_ok), 64'h1);
    chk("haz_byp_rd", 64'(a_byp_rd), 64'h0A6);
    chk("haz_byp_data", a_byp_data, 64'h1234);
    chk("lw_wb_rd", 64'(a_wb_rd), 64'd5);
    chk("lw_wb_res", 64'(a_wb_res), 64'hDEADBEEF);

    // C18: add write-back
    cyc();
    #1;
    chk("add_wb_rd", 64'(a_wb_rd), 64'd6);
    chk("add_wb_res", 64'(a_wb_res), 64'h1234);
    chk("add_not_ready", 64'(a_nr), 64'd0);

    // C19: lw x0
    cyc();
    a_drv(1, 1, 0, 2'd2, 0, 32'h10, 0, 5'd0, 0);
    #1;
    chk("x0_rd_en", 64'(a_rd_en), 64'd1);

    // C20
    cyc();
    a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("x0_not_ready", 64'(a_nr), 64'd0);

    // C21
    cyc();
    a_mem_r = 32'h12345678;
    #1;
    chk("x0_wb_valid", 64'(a_wb_valid), 64'd0);

    // C22: lw x7, then reset mid-flight
    cyc();
    a_drv(1, 1, 0, 2'd2, 0, 32'h20, 0, 5'd7, 0);
    #1;
    chk("flight_rd_en", 64'(a_rd_en), 64'd1);

    // C23
    cyc();
    a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    #1;
    chk("rstmid_not_ready", 64'(a_nr), 64'd0);
    chk("rstmid_wb_valid", 64'(a_wb_valid), 64'd0);
    chk("rstmid_byp_rd", 64'(a_byp_rd), 64'd0);

    // C24
    cyc();
    rstn = 1'b1;
    #1;
    chk("rstpost_not_ready", 64'(a_nr), 64'd0);
    chk("rstpost_wb_valid", 64'(a_wb_valid), 64'd0);

    // C25
    cyc();
    a_mem_r = 32'hFFFFFFFF;
    #1;
    chk("rstpost2_wb_valid", 64'(a_wb_valid), 64'd0);
    chk("rstpost2_wb_res", 64'(a_wb_res), 64'd0);
    chk("rstpost2_mis_addr", 64'(a_mis_addr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
